fnd_capture: RTL

Receive-side monitor for the multiplexed 7-segment FND bus. It samples the active-low digit-select (`fnd_com`) and active-low segment (`fnd_data`) lines, debounces each scan slot, and decodes segment patterns back to BCD digits. When all four digit positions have been captured, it converts them to a 14-bit binary value. It sits on the board-loopback and verification path of the display controller, reconstructing the displayed count for self-check and UART reporting.

---
 rtl/fnd_pkg.sv | 41 ++++
 rtl/fnd_capture_seg_to_bcd.sv | 43 ++++
 rtl/fnd_capture.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND bus capture monitor.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] POS_ONES      = 2'd0;
  localparam logic [1:0] POS_TENS      = 2'd1;
  localparam logic [1:0] POS_HUNDREDS  = 2'd2;
  localparam logic [1:0] POS_THOUSANDS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_e;

  // Position index of an active-low one-hot digit select; only meaningful
  // when the caller has already checked the select is one-hot-low.
  function automatic logic [1:0] com_pos(input logic [3:0] com);
    logic [1:0] pos;
    pos = POS_ONES;
    case (com)
      4'b1101: pos = POS_TENS;
      4'b1011: pos = POS_HUNDREDS;
      4'b0111: pos = POS_THOUSANDS;
      default: pos = POS_ONES;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/fnd_capture_seg_to_bcd.sv
// Segment pattern to BCD decoder. With FND_CAP_DP_EN defined the decimal
// point is excluded from the pattern; otherwise bit7 must be unlit.
module seg_to_bcd
  import fnd_pkg::*;
(
`ifdef FND_CAP_DP_EN
  input  logic [6:0] seg,
`else
  input  logic [7:0] seg,
`endif
  output logic [3:0] digit,
  output logic       blank,
  output logic       err
);

  logic [7:0] pattern;

  always_comb begin
`ifdef FND_CAP_DP_EN
    pattern = {1'b1, seg};
`else
    pattern = seg;
`endif
    digit = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_capture.sv
// Receive-side FND bus monitor: debounces scan slots, decodes digits and
// converts a full frame to binary. Optional dp capture via FND_CAP_DP_EN.
module fnd_capture
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [13:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic [3:0]  blank_mask,
  output logic [3:0]  dp
);

  localparam logic [9:0] CNT_MAX = 10'(SETTLE_CYCLES - 1);

  logic [11:0]      sample_q, sample_d, prev_q, prev_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [3:0][3:0]  digit_q, digit_d, conv_digit_q, conv_digit_d;
  logic [3:0]       blank_q, blank_d, err_q, err_d, dp_q, dp_d;
  logic [3:0]       conv_blank_q, conv_blank_d, conv_err_q, conv_err_d;
  logic [3:0]       conv_dp_q, conv_dp_d;
  logic [3:0]       captured_q, captured_d, captured_next;
  logic [13:0]      acc_q, acc_d, value_q, value_d;
  logic [1:0]       step_q, step_d, conv_sel, cap_pos;
  logic             value_valid_q, value_valid_d, frame_err_q, frame_err_d;
  logic [3:0]       blank_mask_q, blank_mask_d, dp_out_q, dp_out_d;
  state_e           state_q, state_d;

  logic [3:0]       dec_digit;
  logic             dec_blank, dec_err, cap_dp;
  logic             capture, frame_done, conv_en, load_out;

  seg_to_bcd u_dec (
`ifdef FND_CAP_DP_EN
    .seg   (sample_q[6:0]),
`else
    .seg   (sample_q[7:0]),
`endif
    .digit (dec_digit),
    .blank (dec_blank),
    .err   (dec_err)
  );

`ifdef FND_CAP_DP_EN
  assign cap_dp = ~sample_q[7];
`else
  assign cap_dp = 1'b0;
`endif

  // Stability is judged between the two registered samples, so a capture
  // lands SETTLE_CYCLES edges after a pattern is first registered.
  always_comb begin
    sample_d = {fnd_com, fnd_data};
    prev_d   = sample_q;
    if (sample_q != prev_q)
      cnt_d = 10'd0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 10'd1;
    else
      cnt_d = cnt_q;
    capture = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) && $onehot(~sample_q[11:8]);
    cap_pos = com_pos(sample_q[11:8]);
  end

  always_comb begin
    digit_d       = digit_q;
    blank_d       = blank_q;
    err_d         = err_q;
    dp_d          = dp_q;
    captured_next = captured_q;
    if (capture) begin
      digit_d[cap_pos]       = dec_digit;
      blank_d[cap_pos]       = dec_blank;
      err_d[cap_pos]         = dec_err;
      dp_d[cap_pos]          = cap_dp;
      captured_next[cap_pos] = 1'b1;
    end
    frame_done   = (captured_next == 4'hF);
    captured_d   = frame_done ? 4'h0 : captured_next;
    conv_digit_d = frame_done ? digit_d : conv_digit_q;
    conv_blank_d = frame_done ? blank_d : conv_blank_q;
    conv_err_d   = frame_done ? err_d   : conv_err_q;
    conv_dp_d    = frame_done ? dp_d    : conv_dp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A completed frame always restarts conversion from a clean accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_CONV: if (step_q == 2'd3) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (frame_done) state_d = ST_CONV;
  end

  always_comb begin
    conv_en  = (state_q == ST_CONV);
    load_out = (state_q == ST_DONE);
  end

  // Horner accumulation, most significant digit first.
  always_comb begin
    acc_d    = acc_q;
    step_d   = step_q;
    conv_sel = POS_THOUSANDS - step_q;
    if (frame_done) begin
      acc_d  = 14'd0;
      step_d = 2'd0;
    end else if (conv_en) begin
      acc_d  = (acc_q << 3) + (acc_q << 1) + {10'd0, conv_digit_q[conv_sel]};
      step_d = step_q + 2'd1;
    end
    value_d       = load_out ? acc_q        : value_q;
    blank_mask_d  = load_out ? conv_blank_q : blank_mask_q;
    frame_err_d   = load_out ? |conv_err_q  : frame_err_q;
    dp_out_d      = load_out ? conv_dp_q    : dp_out_q;
    value_valid_d = load_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q      <= 12'hFFF;
      prev_q        <= 12'hFFF;
      cnt_q         <= 10'd0;
      digit_q       <= '0;
      blank_q       <= 4'h0;
      err_q         <= 4'h0;
      dp_q          <= 4'h0;
      captured_q    <= 4'h0;
      conv_digit_q  <= '0;
      conv_blank_q  <= 4'h0;
      conv_err_q    <= 4'h0;
      conv_dp_q     <= 4'h0;
      acc_q         <= 14'd0;
      step_q        <= 2'd0;
      value_q       <= 14'd0;
      value_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      blank_mask_q  <= 4'h0;
      dp_out_q      <= 4'h0;
    end else begin
      sample_q      <= sample_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      dp_q          <= dp_d;
      captured_q    <= captured_d;
      conv_digit_q  <= conv_digit_d;
      conv_blank_q  <= conv_blank_d;
      conv_err_q    <= conv_err_d;
      conv_dp_q     <= conv_dp_d;
      acc_q         <= acc_d;
      step_q        <= step_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      frame_err_q   <= frame_err_d;
      blank_mask_q  <= blank_mask_d;
      dp_out_q      <= dp_out_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign frame_err   = frame_err_q;
  assign blank_mask  = blank_mask_q;
  assign dp          = dp_out_q;

endmodule
